// File: rtl/pc_trap_ctrl_pkg.sv
// Shared definitions for the next-PC / machine-mode trap unit.
// Holds the PC mux select codes, CSR addresses, mcause codes, mstatus bit
// positions and the control FSM state type.
package pc_trap_ctrl_pkg;

  // PC multiplexer select codes (3'b010 is reserved and never driven)
  localparam logic [2:0] PC_SEL_PC4    = 3'b000;
  localparam logic [2:0] PC_SEL_BRANCH = 3'b001;
  localparam logic [2:0] PC_SEL_JAL    = 3'b011;
  localparam logic [2:0] PC_SEL_JALR   = 3'b100;
  localparam logic [2:0] PC_SEL_EXC    = 3'b101;
  localparam logic [2:0] PC_SEL_MRET   = 3'b111;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mcause codes
  localparam logic [31:0] MCAUSE_MISALIGNED = 32'd0;
  localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] MCAUSE_ECALL      = 32'd11;
  localparam logic [31:0] MCAUSE_EXT_IRQ    = 32'h8000_000B;

  // mstatus / mie / mip bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MEIE_BIT         = 11;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode trap CSRs: mstatus (MIE/MPIE), mie (MEIE), mip, mtvec, mepc, mcause.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   trap_i             trap entry this cycle (save pc/cause, stack MIE)
//   trap_pc_i          pc saved into mepc on trap
//   trap_cause_i       value loaded into mcause on trap
//   mret_i             MRET this cycle (unstack MIE)
//   csr_we_i           software CSR write, already gated against trap/MRET/flush
//   csr_addr_i         CSR address for read and write
//   csr_wdata_i        CSR write data
//   irq_ext_i          external interrupt level, reflected in mip
//   csr_rdata_o        combinational CSR read data
//   mstatus_mie_o      global interrupt enable
//   mie_meie_o         external interrupt enable
//   trap_target_o      word-aligned mtvec
//   ret_target_o       word-aligned mepc
module trap_csr_file
  import pc_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        irq_ext_i,
  output logic [31:0] csr_rdata_o,
  output logic        mstatus_mie_o,
  output logic        mie_meie_o,
  output logic [31:0] trap_target_o,
  output logic [31:0] ret_target_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  // Trap and MRET take precedence; a coincident software write is dropped.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (trap_i) begin
      mepc_d   = trap_pc_i;
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we_i) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata_i[MSTATUS_MIE_BIT];
          mpie_d = csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    meie_d   = csr_wdata_i[MEIE_BIT];
        CSR_MTVEC:  mtvec_d  = csr_wdata_i;
        CSR_MEPC:   mepc_d   = {csr_wdata_i[31:2], 2'b00};
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      meie_q   <= meie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  always_comb begin
    csr_rdata_o = 32'd0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE_BIT]  = mie_q;
        csr_rdata_o[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE:    csr_rdata_o[MEIE_BIT] = meie_q;
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MIP:    csr_rdata_o[MEIE_BIT] = irq_ext_i;
      default: ;
    endcase
  end

  assign mstatus_mie_o = mie_q;
  assign mie_meie_o    = meie_q;
  assign trap_target_o = {mtvec_q[31:2], 2'b00};
  assign ret_target_o  = {mepc_q[31:2], 2'b00};

endmodule

// File: rtl/pc_trap_ctrl.sv
// Next-PC select and machine-mode trap sequencing for the RV32 core.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   instr_valid_i, pc_cur_i  retiring instruction and its PC
//   branch_taken_i, is_jal_i, is_jalr_i, is_mret_i   control-flow events
//   exc_misaligned_i, exc_illegal_i, exc_ecall_i     synchronous exceptions
//   irq_ext_i                level-sensitive external interrupt
//   csr_we_i, csr_addr_i, csr_wdata_i, csr_rdata_o   CSR access port
//   Control_PC_Mux_o         PC mux select
//   PC_Exception_o           trap target
//   MRET_o                   MRET return target
//   flush_o                  one-cycle kill of the younger instruction
module pc_trap_ctrl
  import pc_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_cur_i,
  input  logic        branch_taken_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        is_mret_i,
  input  logic        exc_misaligned_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ecall_i,
  input  logic        irq_ext_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic [2:0]  Control_PC_Mux_o,
  output logic [31:0] PC_Exception_o,
  output logic [31:0] MRET_o,
  output logic        flush_o
);

  state_e      state_q;
  logic        flush_q;
  logic        run;
  logic        exc_any;
  logic        irq_take;
  logic        trap;
  logic        mret_take;
  logic        csr_we_eff;
  logic [31:0] trap_cause;
  logic        mstatus_mie;
  logic        mie_meie;

  always_comb begin
    run       = (state_q == StRun);
    exc_any   = instr_valid_i & (exc_misaligned_i | exc_illegal_i | exc_ecall_i);
    // Interrupts are sampled even without a valid instruction.
    irq_take  = irq_ext_i & mstatus_mie & mie_meie;
    trap      = run & (exc_any | irq_take);
    mret_take = run & instr_valid_i & is_mret_i & ~exc_any & ~irq_take;
    csr_we_eff = run & csr_we_i & ~trap & ~mret_take;

    if (instr_valid_i && exc_misaligned_i) begin
      trap_cause = MCAUSE_MISALIGNED;
    end else if (instr_valid_i && exc_illegal_i) begin
      trap_cause = MCAUSE_ILLEGAL;
    end else if (instr_valid_i && exc_ecall_i) begin
      trap_cause = MCAUSE_ECALL;
    end else begin
      trap_cause = MCAUSE_EXT_IRQ;
    end

    Control_PC_Mux_o = PC_SEL_PC4;
    if (run) begin
      if (exc_any || irq_take) begin
        Control_PC_Mux_o = PC_SEL_EXC;
      end else if (instr_valid_i) begin
        if (is_mret_i) begin
          Control_PC_Mux_o = PC_SEL_MRET;
        end else if (is_jalr_i) begin
          Control_PC_Mux_o = PC_SEL_JALR;
        end else if (is_jal_i) begin
          Control_PC_Mux_o = PC_SEL_JAL;
        end else if (branch_taken_i) begin
          Control_PC_Mux_o = PC_SEL_BRANCH;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StRun;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (trap || mret_take) begin
            state_q <= StFlush;
            flush_q <= 1'b1;
          end
        end
        StFlush: begin
          state_q <= StRun;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= StRun;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o = flush_q;

  trap_csr_file #(
    .RESET_MTVEC(RESET_MTVEC)
  ) u_csr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .trap_i       (trap),
    .trap_pc_i    (pc_cur_i),
    .trap_cause_i (trap_cause),
    .mret_i       (mret_take),
    .csr_we_i     (csr_we_eff),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .irq_ext_i    (irq_ext_i),
    .csr_rdata_o  (csr_rdata_o),
    .mstatus_mie_o(mstatus_mie),
    .mie_meie_o   (mie_meie),
    .trap_target_o(PC_Exception_o),
    .ret_target_o (MRET_o)
  );

endmodule

// File: doc/pc_trap_ctrl.md
# pc_trap_ctrl

Next-PC control and machine-mode trap unit for the single-issue RV32 core. It drives the 3-bit select code, exception target and return target consumed by the PC multiplexer. It also owns the trap CSRs mstatus, mie, mip, mtvec, mepc and mcause. It sequences trap entry and MRET through a small FSM that issues a one-cycle pipeline flush.

## Interface
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  current instruction is valid and retiring this cycle
- pc_cur  in  32  PC of the current instruction
- branch_taken, is_jal, is_jalr, is_mret  in  1 each  decoded control-flow events
- exc_misaligned, exc_illegal, exc_ecall  in  1 each  synchronous exceptions of current instruction
- irq_ext  in  1  level-sensitive external interrupt
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  CSR read data, combinational
- Control_PC_Mux  out  3  select: 000 PC+4, 001 branch, 011 jal, 100 jalr, 101 exception, 111 MRET; 010 reserved, never driven
- PC_Exception  out  32  trap target, {mtvec[31:2],2'b00}
- MRET  out  32  return target, {mepc[31:2],2'b00}
- flush  out  1  kill younger in-flight instruction

## Operation
- FSM states are RUN and FLUSH. Reset state is RUN.
- RUN with instr_valid=1: select by priority.
  - exception (exc_misaligned > exc_illegal > exc_ecall): 101
  - interrupt (irq_ext & mstatus.MIE & mie.MEIE): 101
  - is_mret: 111
  - is_jalr: 100
  - is_jal: 011
  - branch_taken: 001
  - otherwise: 000
- RUN with instr_valid=0: select 000. Only interrupts are evaluated; an interrupt still selects 101 and takes pc_cur as mepc.
- Trap entry (exception or interrupt):
  - mepc <= pc_cur
  - mcause <= 0 (misaligned), 2 (illegal), 11 (ecall), 32'h8000_000B (external interrupt)
  - MPIE <= MIE, MIE <= 0
  - next state FLUSH
- MRET: MIE <= MPIE, MPIE <= 1, next state FLUSH.
- FLUSH: flush=1, select 000, all event inputs and csr_we ignored, next state RUN.
- CSR map:
  - mstatus 0x300: bits 3 (MIE) and 7 (MPIE) writable, others read 0
  - mie 0x304: bit 11 (MEIE) writable
  - mtvec 0x305: full 32-bit write, read as written
  - mepc 0x341: bits [1:0] forced to 0 on write
  - mcause 0x342: full write
  - mip 0x344: read-only, bit 11 = irq_ext
  - unmapped addresses read 0, writes dropped
- Simultaneous trap/MRET and csr_we in the same cycle: the trap or MRET update wins and the CSR write is discarded.

## Timing
- Control_PC_Mux, PC_Exception, MRET and csr_rdata are combinational from inputs and current register state, with zero latency.
- CSR and FSM updates take effect on the next rising edge. A trap cycle's PC_Exception uses the pre-edge mtvec.
- Reset values:
  - mstatus=0, mie=0, mepc=0, mcause=0, mtvec=RESET_MTVEC
  - state RUN, flush=0, Control_PC_Mux=000
- Reset asserted during FLUSH returns the unit to RUN with all CSRs at their reset values; the pending flush is dropped.
- Back-to-back events: an event arriving in the FLUSH cycle is ignored. An interrupt asserted while MIE=0 stays pending (level) and is taken in the first RUN cycle after MIE becomes 1.

## Structure
- Shared package holds:
  - PC_SEL_* localparams (000/001/011/100/101/111)
  - CSR address constants
  - mcause codes
  - mstatus bit indices MIE=3, MPIE=7
- One sub-module, trap_csr_file: CSR registers, read mux and write decode, with trap/MRET update ports.
- FSM and select priority logic stay in pc_trap_ctrl.

## Test plan
- After reset, instr_valid=1 with no events: Control_PC_Mux=000, PC_Exception=32'h100, MRET=0, flush=0.
- pc_cur=32'h40, exc_illegal=1 and is_jal=1 together: select 101; next cycle mepc=32'h40, mcause=2, flush=1; following cycle flush=0.
- Write mstatus=32'h8, mie=32'h800, then raise irq_ext with instr_valid=0: select 101, mcause=32'h8000_000B, MIE=0, MPIE=1.
- Trap taken, then is_mret=1: select 111, MRET=mepc; next cycle MIE=1, flush=1.
- csr_we to mtvec=32'h200 in the same cycle as exc_ecall: mtvec stays 32'h100 and mcause=11.
- rst_n=0 in the FLUSH cycle: next cycle state RUN, flush=0, mepc=0, mtvec=32'h100.
